// File: rtl/clk_enable_pkg.sv
// Shared definitions for the clock-enable generator.
//   NCH_MAX     : largest supported channel count
//   DIV_RST_DEF : divisor each channel loads at reset
//   ch_idx_w()  : width of a channel index, never less than 1
package clk_enable_pkg;

  localparam int unsigned NCH_MAX     = 16;
  localparam int unsigned DIV_RST_DEF = 4;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/clk_enable_ch.sv
// One divider channel: counter, active/shadow divisor, tick strobe, square wave.
//   clk, rst : master clock, async active-high reset
//   en       : run enable; low holds the channel at zero
//   sync     : phase-align, restarts the count from zero
//   wr       : shadow write strobe (only raised while not pending)
//   wr_div   : divisor to store in the shadow register
//   pending  : shadow holds a divisor not yet applied
//   tick     : one-cycle enable strobe every div_act cycles
//   sq       : square wave, toggles on every tick
module clk_enable_ch
  import clk_enable_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic             wrap;
  logic             restart;

  // >= rather than == keeps the counter bounded even if it were ever ahead
  always_comb begin
    wrap    = (cnt >= div_act - ONE);
    restart = sync | ~en | wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_act <= DIV_INIT;
      div_shd <= DIV_INIT;
      pending <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt  <= '0;
        tick <= 1'b0;
        sq   <= 1'b0;
      end else if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
      end

      // A new divisor only takes effect where the count restarts from zero,
      // so no period is ever cut short or stretched mid-count.
      if (pending && restart) begin
        div_act <= div_shd;
        pending <= 1'b0;
      end else if (wr) begin
        div_shd <= wr_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with double-buffered divisors.
//   clk, rst  : master clock, async active-high reset
//   en        : per-channel run enable
//   sync      : phase-align all channels
//   cfg_valid : divisor write request
//   cfg_ch    : target channel of the write
//   cfg_div   : requested divisor (0 is rejected)
//   cfg_ready : write accepted this cycle when high with cfg_valid
//   cfg_err   : one-cycle pulse for a rejected write
//   tick      : per-channel one-cycle enable strobe
//   sq        : per-channel square wave
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned CNT_W   = 32,
  parameter  int unsigned DIV_RST = DIV_RST_DEF,
  localparam int unsigned CH_W    = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  logic [NCH-1:0]          pending;
  logic [(1 << CH_W)-1:0]  pending_ext;
  logic [NCH-1:0]          wr;
  logic                    ch_ok;
  logic                    div_ok;
  logic                    accept;

  // Nonexistent channels read as not pending so the write is taken and flagged.
  always_comb begin
    pending_ext          = '0;
    pending_ext[NCH-1:0] = pending;
  end

  always_comb begin
    ch_ok     = (32'(cfg_ch) < NCH);
    div_ok    = (cfg_div != '0);
    cfg_ready = ~pending_ext[cfg_ch];
    accept    = cfg_valid & cfg_ready;
    wr        = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      wr[i] = accept & ch_ok & div_ok & (32'(cfg_ch) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept & ~(ch_ok & div_ok);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_enable_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .pending (pending[g]),
      .tick    (tick[g]),
      .sq      (sq[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
module tb_clk_enable_gen;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           cfg_valid;
  logic [CW-1:0]  cfg_ch;
  logic [31:0]    cfg_div;
  logic           cfg_ready;
  logic           cfg_err;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;

  clk_enable_gen #(
    .NCH     (NCH),
    .CNT_W   (32),
    .DIV_RST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .sq        (sq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Timing model: a channel ticks when exactly div edges have elapsed since
  // its last restart (reset, sync, disabled edge, or previous tick).
  int             ecount;
  int             m_div   [NCH];
  int             m_sh    [NCH];
  bit             m_pend  [NCH];
  int             m_start [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;
  logic           m_err;

  task automatic m_init();
    ecount = 0;
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = 4; m_sh[c] = 4; m_pend[c] = 0; m_start[c] = 0;
    end
    m_tick = '0; m_sq = '0; m_err = 1'b0;
  endtask

  task automatic m_step();
    bit rdy;
    bit rs;
    int wch;
    ecount++;
    rdy   = !m_pend[cfg_ch];
    m_err = cfg_valid && rdy && (cfg_div == 0);
    wch   = (cfg_valid && rdy && cfg_div != 0) ? int'(cfg_ch) : -1;
    for (int c = 0; c < NCH; c++) begin
      rs = 0;
      if (sync || !en[c]) begin
        m_tick[c] = 1'b0; m_sq[c] = 1'b0; rs = 1;
      end else if (ecount - m_start[c] == m_div[c]) begin
        m_tick[c] = 1'b1; m_sq[c] = ~m_sq[c]; rs = 1;
      end else begin
        m_tick[c] = 1'b0;
      end
      if (rs) begin
        m_start[c] = ecount;
        if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
      end
      if (wch == c) begin m_sh[c] = int'(cfg_div); m_pend[c] = 1; end
    end
  endtask

  initial begin
    m_init();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_init();
      else     m_step();
    end
  end

  always @(negedge clk) begin
    chk("tick",      32'(tick),      32'(m_tick));
    chk("sq",        32'(sq),        32'(m_sq));
    chk("cfg_err",   32'(cfg_err),   32'(m_err));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic to_edge(input int n);
    while (ecount < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = '1; sync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    #12;
    chk("rst_tick",  32'(tick),      32'd0);
    chk("rst_sq",    32'(sq),        32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    #10 rst = 1'b0;

    to_edge(3);  chk("e3_tick0", 32'(tick[0]), 32'd0);
    to_edge(4);  chk("e4_tick",  32'(tick), 32'hF);
                 chk("e4_sq0",   32'(sq[0]), 32'd1);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd10;
    to_edge(5);  cfg_valid = 1'b0;
    to_edge(7);  chk("e7_ready1", 32'(cfg_ready), 32'd0);
    to_edge(8);  chk("e8_tick",   32'(tick), 32'hF);
                 chk("e8_sq",     32'(sq), 32'h0);
                 chk("e8_ready1", 32'(cfg_ready), 32'd1);
    to_edge(12); chk("e12_tick0", 32'(tick[0]), 32'd1);

    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 32'd0;
    to_edge(13); cfg_valid = 1'b0;
                 chk("e13_err", 32'(cfg_err), 32'd1);
    to_edge(14); chk("e14_err", 32'(cfg_err), 32'd0);
    to_edge(16); chk("e16_tick0", 32'(tick[0]), 32'd1);
    to_edge(18); chk("e18_tick",  32'(tick), 32'h2);

    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 32'd1;
    to_edge(19); cfg_valid = 1'b0;
    to_edge(20); chk("e20_tick", 32'(tick), 32'hD);
    to_edge(21); chk("e21_tick", 32'(tick), 32'h4);
                 chk("e21_sq2",  32'(sq[2]), 32'd0);
    to_edge(22); chk("e22_sq2",  32'(sq[2]), 32'd1);
    to_edge(27); chk("e27_tick", 32'(tick), 32'h4);
    to_edge(28); chk("e28_tick", 32'(tick), 32'hF);

    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd3;
    to_edge(29); cfg_valid = 1'b0; sync = 1'b1;
    to_edge(30); sync = 1'b0;
                 chk("e30_tick", 32'(tick), 32'h0);
                 chk("e30_sq",   32'(sq), 32'h0);
    to_edge(31); chk("e31_tick", 32'(tick), 32'h4);
    to_edge(33); chk("e33_tick", 32'(tick), 32'hC);
    to_edge(34); chk("e34_tick0", 32'(tick[0]), 32'd1);
    to_edge(39); chk("e39_tick1", 32'(tick[1]), 32'd0);
    to_edge(40); chk("e40_tick1", 32'(tick[1]), 32'd1);

    en = 4'b0111; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 32'd5;
    to_edge(41); cfg_valid = 1'b0;
                 chk("e41_tick3",  32'(tick[3]), 32'd0);
                 chk("e41_sq3",    32'(sq[3]), 32'd0);
                 chk("e41_ready3", 32'(cfg_ready), 32'd0);
    to_edge(42); chk("e42_ready3", 32'(cfg_ready), 32'd1);
    en = 4'b1111;
    to_edge(46); chk("e46_tick3", 32'(tick[3]), 32'd0);
    to_edge(47); chk("e47_tick3", 32'(tick[3]), 32'd1);

    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd7;
    to_edge(49); cfg_valid = 1'b0;
                 chk("e49_ready1", 32'(cfg_ready), 32'd0);
    to_edge(51);
    #1 rst = 1'b1;
    #1;
    chk("arst_tick",  32'(tick), 32'h0);
    chk("arst_sq",    32'(sq), 32'h0);
    chk("arst_err",   32'(cfg_err), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    #14 rst = 1'b0;
    to_edge(3);  chk("r3_tick0", 32'(tick[0]), 32'd0);
    to_edge(4);  chk("r4_tick",  32'(tick), 32'hF);
    to_edge(8);  chk("r8_tick1", 32'(tick[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
